inv_key_expander: RTL and testbench
===================================

INV_KEY_EXPANDER -- requirements
Module: inv_key_expander

Interface
REQ-001 Parameter BYTE, default 8, bits per byte.
REQ-002 Parameter WORD, default 32, bits per key word.
REQ-003 Parameter Nb, default 128, bits per round key.
REQ-004 Parameter Nr, default 10, number of rounds (AES-128).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to begin a regeneration run.
REQ-008 last_key  input  Nb  round-Nr key, word 0 in bits [Nb-1:Nb-WORD]; sampled only on an accepted start.
REQ-009 key_ready  input  1  downstream accepts round_key this cycle.
REQ-010 busy  output  1  run in progress; start ignored while high.
REQ-011 key_valid  output  1  round_key/round_idx hold a valid key.
REQ-012 round_key  output  Nb  current round key, same word order as last_key.
REQ-013 round_idx  output  4  round number of round_key, Nr down to 0.
REQ-014 done  output  1  one-cycle pulse after round-0 key is accepted.

Function
REQ-015 The block SHALL regenerate round keys Nr..0 in descending order, one key per handshake (key_valid && key_ready).
REQ-016 FSM states SHALL be IDLE and EMIT; IDLE->EMIT on start while idle; EMIT->IDLE on handshake with round_idx==0.
REQ-017 Start accepted at cycle N SHALL present last_key with round_idx=Nr and key_valid=1 at cycle N+1.
REQ-018 On handshake with round_idx=r>0, the next cycle SHALL present key r-1, round_idx=r-1; sustained key_ready yields one key per cycle, 11 keys in 11 cycles.
REQ-019 Inverse step for key r words w0..w3: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon(r).
REQ-020 Rcon(r) SHALL be {rc,24'h0}, rc = 01,02,04,08,10,20,40,80,1B,36 for r=1..10.
REQ-021 While key_valid && !key_ready, round_key and round_idx SHALL hold stable.
REQ-022 busy SHALL equal (state==EMIT); start while busy SHALL be ignored and not queued.
REQ-023 done SHALL pulse exactly one cycle after the round-0 handshake; start in that same cycle SHALL be accepted.
REQ-024 All XORs are bitwise on WORD-wide words; no carries or width extension.

Reset
REQ-025 rst SHALL asynchronously force IDLE, busy=0, key_valid=0, done=0, round_idx=0, round_key=0.
REQ-026 rst mid-run SHALL abandon the run; no further keys until a new start after release.

Configuration
REQ-027 With INV_KEY_ABORT_EN defined, input abort (1 bit) SHALL force IDLE, key_valid=0, no done pulse, on the next edge; abort has priority over a same-cycle handshake.
REQ-028 Without INV_KEY_ABORT_EN, the abort port and its logic SHALL not exist.

Structure
REQ-029 Shared package aes_pkg SHALL hold BYTE/WORD/Nb/Nr constants, the Rcon table/function and the FSM state type.
REQ-030 Sub-module inv_key_step SHALL implement REQ-019 combinationally, reusing the existing S-box and rotate cells; inv_key_expander holds only FSM and registers.

Verification
REQ-031 Start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> idx10 that key, idx9 ac7766f319fadc2128d12941575c006e, ..., idx0 2b7e151628aed2a6abf7158809cf4f3c, done pulse.
REQ-032 Same run, key_ready low for 3 cycles at idx5 -> round_key/idx stable, no key skipped or repeated.
REQ-033 start pulsed at idx7 with different last_key -> ignored; sequence completes from original key.
REQ-034 rst asserted at idx4 -> outputs zero immediately; new start after release yields idx10 first.
REQ-035 INV_KEY_ABORT_EN: abort with handshake at idx3 -> IDLE next cycle, key_valid=0, no done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box/Rcon/rotate helpers and the key-regeneration FSM state type.
package aes_pkg;

  localparam int unsigned AES_BYTE = 8;
  localparam int unsigned AES_WORD = 32;
  localparam int unsigned AES_NB   = 128;
  localparam int unsigned AES_NR   = 10;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x occupies bits [8*(255-x)+7 -: 8], i.e. {~x, 3'b111} as the top index.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon_byte(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_expander_if.sv
// Handshake bundle for inv_key_expander; abort exists only when INV_KEY_ABORT_EN is defined.
interface inv_key_expander_if #(
  parameter int unsigned Nb = aes_pkg::AES_NB
);
  logic          start;
  logic [Nb-1:0] last_key;
  logic          key_ready;
`ifdef INV_KEY_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          key_valid;
  logic [Nb-1:0] round_key;
  logic [3:0]    round_idx;
  logic          done;

  modport master (
    output start, last_key, key_ready,
`ifdef INV_KEY_ABORT_EN
    output abort,
`endif
    input  busy, key_valid, round_key, round_idx, done
  );

  modport slave (
    input  start, last_key, key_ready,
`ifdef INV_KEY_ABORT_EN
    input  abort,
`endif
    output busy, key_valid, round_key, round_idx, done
  );
endinterface

// File: rtl/inv_key_step.sv
// One inverse AES-128 key-schedule step: derives round key r-1 from round key r.
module inv_key_step
  import aes_pkg::*;
#(
  parameter int unsigned BYTE = AES_BYTE,
  parameter int unsigned WORD = AES_WORD,
  parameter int unsigned Nb   = AES_NB
) (
  input  logic [Nb-1:0] key_in,
  input  logic [3:0]    round,
  output logic [Nb-1:0] key_out
);

  logic [WORD-1:0] w0, w1, w2, w3;
  logic [WORD-1:0] p0, p1, p2, p3;
  logic [WORD-1:0] rot, sub;

  assign w0 = key_in[Nb-1        -: WORD];
  assign w1 = key_in[Nb-1-WORD   -: WORD];
  assign w2 = key_in[Nb-1-2*WORD -: WORD];
  assign w3 = key_in[Nb-1-3*WORD -: WORD];

  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = rot_word(p3);

  always_comb begin
    sub = '0;
    for (int unsigned i = 0; i < WORD / BYTE; i++) begin
      sub[i*BYTE +: BYTE] = sbox(rot[i*BYTE +: BYTE]);
    end
  end

  assign p0      = w0 ^ sub ^ {rcon_byte(round), {(WORD-8){1'b0}}};
  assign key_out = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_key_expander.sv
// Replays AES-128 round keys Nr..0 from the final round key, one per valid/ready handshake.
// Optional INV_KEY_ABORT_EN adds an abort input that drops the run on the next edge.
module inv_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned BYTE = AES_BYTE,
  parameter int unsigned WORD = AES_WORD,
  parameter int unsigned Nb   = AES_NB,
  parameter int unsigned Nr   = AES_NR
) (
  input logic                 clk,
  input logic                 rst,
  inv_key_expander_if.slave   bus
);

  state_e        state_q, state_d;
  logic          key_valid_q, key_valid_d;
  logic [Nb-1:0] round_key_q, round_key_d;
  logic [3:0]    round_idx_q, round_idx_d;
  logic          done_q, done_d;
  logic [Nb-1:0] prev_key;
  logic          hs;

  inv_key_step #(
    .BYTE (BYTE),
    .WORD (WORD),
    .Nb   (Nb)
  ) u_step (
    .key_in  (round_key_q),
    .round   (round_idx_q),
    .key_out (prev_key)
  );

  assign hs = key_valid_q & bus.key_ready;

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = EMIT;
          key_valid_d = 1'b1;
          round_key_d = bus.last_key;
          round_idx_d = 4'(Nr);
        end
      end
      EMIT: begin
        if (hs) begin
          if (round_idx_q == 4'd0) begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            round_key_d = prev_key;
            round_idx_d = round_idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef INV_KEY_ABORT_EN
    // Abort wins over a same-cycle handshake, including the round-0 one, so no done pulse.
    if (bus.abort) begin
      state_d     = IDLE;
      key_valid_d = 1'b0;
      done_d      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      round_key_q <= '0;
      round_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == EMIT);
  assign bus.key_valid = key_valid_q;
  assign bus.round_key = round_key_q;
  assign bus.round_idx = round_idx_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_inv_key_expander.sv
// Scoreboard bench for inv_key_expander using the FIPS-197 AES-128 example key schedule.
module tb_inv_key_expander;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic clk;
  logic rst;
  logic abort_s;

  inv_key_expander_if #(.Nb(128)) bus ();

  inv_key_expander #(
    .BYTE (8),
    .WORD (32),
    .Nb   (128),
    .Nr   (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef INV_KEY_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] exp_key [0:10];
  exp_t         sb_q [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           done_cnt = 0;
  logic         done_pend = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_run;
    for (int r = 10; r >= 0; r--) sb_q.push_back('{idx: 4'(r), key: exp_key[r]});
  endtask

  task automatic start_run(input logic [127:0] k);
    bus.last_key = k;
    bus.start    = 1'b1;
    push_run();
    tick();
    bus.start = 1'b0;
    check("start_valid", {127'd0, bus.key_valid}, 128'd1);
    check("start_idx", {124'd0, bus.round_idx}, 128'd10);
  endtask

  task automatic run_to_end(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      tick();
      cnt++;
    end
    check("run_end_busy", {127'd0, bus.busy}, 128'd0);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(bus.key_valid && bus.round_idx == 4'(idx)) && n < 40) begin
      tick();
      n++;
    end
    check("wait_idx", {123'd0, bus.key_valid, bus.round_idx}, {123'd0, 1'b1, 4'(idx)});
  endtask

  // Monitor: pops an expectation on every handshake and checks the done pulse timing.
  always @(negedge clk) begin
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      if (done_pend || bus.done) check("done_pulse", {127'd0, bus.done}, {127'd0, done_pend});
      if (bus.done) done_cnt++;
      done_pend = 1'b0;
      if (bus.key_valid && bus.key_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_key: got idx %0d key %h expected none", bus.round_idx, bus.round_key);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("key_idx", {124'd0, bus.round_idx}, {124'd0, e.idx});
          check("round_key", bus.round_key, e.key);
        end
        if (bus.round_idx == 4'd0 && !abort_s) done_pend = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.last_key  = '0;
    bus.key_ready = 1'b0;
`ifdef INV_KEY_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #2 rst = 1'b1;
    #2;
    check("rst_busy", {127'd0, bus.busy}, 128'd0);
    check("rst_valid", {127'd0, bus.key_valid}, 128'd0);
    check("rst_done", {127'd0, bus.done}, 128'd0);
    check("rst_idx", {124'd0, bus.round_idx}, 128'd0);
    check("rst_key", bus.round_key, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Run 1: sustained ready, eleven keys in eleven cycles.
    bus.key_ready = 1'b1;
    start_run(exp_key[10]);
    run_to_end(cnt);
    check("run1_cycles", 128'(cnt), 128'd11);
    check("run1_done", {127'd0, bus.done}, 128'd1);

    // Run 2 starts in the done cycle; ready drops for three cycles at idx5.
    start_run(exp_key[10]);
    wait_idx(5);
    bus.key_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_idx", {124'd0, bus.round_idx}, 128'd5);
      check("stall_key", bus.round_key, exp_key[5]);
      check("stall_valid", {127'd0, bus.key_valid}, 128'd1);
    end
    bus.key_ready = 1'b1;
    run_to_end(cnt);
    tick();

    // Run 3: start with another key while busy is ignored.
    start_run(exp_key[10]);
    wait_idx(7);
    bus.last_key = 128'h00112233445566778899aabbccddeeff;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start_ignored", {127'd0, bus.busy}, 128'd1);
    check("busy_start_idx", {124'd0, bus.round_idx}, 128'd6);
    run_to_end(cnt);
    tick();

    // Run 4: asynchronous reset at idx4, then a fresh run.
    start_run(exp_key[10]);
    wait_idx(4);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {127'd0, bus.key_valid}, 128'd0);
    check("midrst_busy", {127'd0, bus.busy}, 128'd0);
    check("midrst_idx", {124'd0, bus.round_idx}, 128'd0);
    check("midrst_key", bus.round_key, 128'd0);
    check("midrst_done", {127'd0, bus.done}, 128'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", {127'd0, bus.key_valid}, 128'd0);
    start_run(exp_key[10]);
    run_to_end(cnt);
    tick();

`ifdef INV_KEY_ABORT_EN
    // Abort together with the idx3 handshake: idle next cycle, no done.
    start_run(exp_key[10]);
    wait_idx(3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", {127'd0, bus.key_valid}, 128'd0);
    check("abort_busy", {127'd0, bus.busy}, 128'd0);
    check("abort_done", {127'd0, bus.done}, 128'd0);
    sb_q.delete();
    tick();
    check("abort_done_late", {127'd0, bus.done}, 128'd0);
    tick();
`endif

    check("done_count", 128'(done_cnt), 128'd4);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
